// File: rtl/gate_truth_checker.sv
// gate_truth_checker: drives the four {a,b} vectors into an external 2-input gate
// and checks y against the truth table of the selected gate type.
`default_nettype none

module gate_truth_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] gate_sel,
    output logic       a,
    output logic       b,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] c_SETTLE = 4'(SETTLE_CYCLES);

    state_t     r_state, w_state;
    logic [3:0] r_cnt,   w_cnt;
    logic [2:0] r_gate,  w_gate;
    logic [1:0] r_ab,    w_ab;
    logic [2:0] r_err,   w_err;
    logic [3:0] r_fail,  w_fail;
    logic       r_pass,  w_pass;
    logic       w_exp;
    logic       w_match;

    always_comb begin
        w_exp = 1'b0;
        case (r_gate)
            3'd0:    w_exp =   r_ab[1] & r_ab[0];
            3'd1:    w_exp =   r_ab[1] | r_ab[0];
            3'd2:    w_exp = ~(r_ab[1] & r_ab[0]);
            3'd3:    w_exp = ~(r_ab[1] | r_ab[0]);
            3'd4:    w_exp =   r_ab[1] ^ r_ab[0];
            3'd5:    w_exp = ~(r_ab[1] ^ r_ab[0]);
            default: w_exp = 1'b0;
        endcase
    end

    // An unknown y makes the equality unknown, so the match flag stays clear.
    always_comb begin
        w_match = 1'b0;
        if (y == w_exp) begin
            w_match = 1'b1;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_gate  = r_gate;
        w_ab    = r_ab;
        w_err   = r_err;
        w_fail  = r_fail;
        w_pass  = r_pass;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_gate = gate_sel;
                    w_ab   = 2'b00;
                    w_cnt  = c_SETTLE;
                    w_pass = 1'b0;
                    if (gate_sel > 3'd5) begin
                        w_err   = 3'd4;
                        w_fail  = 4'b1111;
                        w_state = ST_DONE;
                    end else begin
                        w_err   = 3'd0;
                        w_fail  = 4'b0000;
                        w_state = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (r_cnt <= 4'd1) begin
                    w_cnt   = 4'd0;
                    w_state = ST_CHECK;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            ST_CHECK: begin
                if (!w_match) begin
                    w_err  = r_err + 3'd1;
                    w_fail = r_fail | (4'b0001 << r_ab);
                end
                if (r_ab != 2'b11) begin
                    w_ab    = r_ab + 2'b01;
                    w_cnt   = c_SETTLE;
                    w_state = ST_SETTLE;
                end else begin
                    w_pass  = (r_err == 3'd0) && w_match;
                    w_state = ST_DONE;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_gate  <= 3'd0;
            r_ab    <= 2'b00;
            r_err   <= 3'd0;
            r_fail  <= 4'b0000;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_gate  <= w_gate;
            r_ab    <= w_ab;
            r_err   <= w_err;
            r_fail  <= w_fail;
            r_pass  <= w_pass;
        end
    end

    assign a         = r_ab[1];
    assign b         = r_ab[0];
    assign busy      = (r_state == ST_SETTLE) || (r_state == ST_CHECK);
    assign done      = (r_state == ST_DONE);
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail;

endmodule

`default_nettype wire

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker: scoreboard bench driving gate_truth_checker against
// simple gate models (NAND, AND, stuck-at-0).
`default_nettype none

module tb_gate_truth_checker;

    localparam int S = 2;
    localparam int P = S + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] gate_sel = 3'd0;
    logic       a, b, y, busy, done, pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;
    int         model = 0;   // 0 NAND, 1 AND, 2 stuck-at-0

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       p;
        logic [2:0] e;
        logic [3:0] f;
    } exp_t;
    exp_t sb[$];

    gate_truth_checker #(.SETTLE_CYCLES(S)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .gate_sel  (gate_sel),
        .a         (a),
        .b         (b),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec)
    );

    always #5 clk = ~clk;

    always_comb begin
        y = 1'b0;
        case (model)
            0:       y = ~(a & b);
            1:       y = a & b;
            default: y = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_gate(input logic [2:0] sel, input logic [1:0] v);
        case (sel)
            3'd0:    return v[1] & v[0];
            3'd1:    return v[1] | v[0];
            3'd2:    return ~(v[1] & v[0]);
            3'd3:    return ~(v[1] | v[0]);
            3'd4:    return v[1] ^ v[0];
            default: return ~(v[1] ^ v[0]);
        endcase
    endfunction

    function automatic logic model_y(input int m, input logic [1:0] v);
        case (m)
            0:       return ~(v[1] & v[0]);
            1:       return v[1] & v[0];
            default: return 1'b0;
        endcase
    endfunction

    task automatic push_exp(input logic [2:0] sel, input int m);
        exp_t x;
        x = '0;
        if (sel > 3'd5) begin
            x.e = 3'd4;
            x.f = 4'b1111;
        end else begin
            for (int v = 0; v < 4; v++) begin
                if (ref_gate(sel, 2'(v)) != model_y(m, 2'(v))) begin
                    x.e = x.e + 3'd1;
                    x.f[v] = 1'b1;
                end
            end
            x.p = (x.e == 3'd0);
        end
        sb.push_back(x);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entered just after the start edge; returns just after the edge ending the done pulse.
    task automatic wait_done(input logic [2:0] sel, input bit toggle);
        int   k;
        exp_t x;
        k = 0;
        while (!done && k < 200) begin
            if (k % P == 0 && k < 4 * P) begin
                check("ab_step", {30'd0, a, b}, k / P);
                check("busy_run", busy, 1);
            end
            if (toggle) gate_sel = ~gate_sel;
            tick;
            k++;
        end
        check("done_latency", k, (sel > 3'd5) ? 0 : 4 * P);
        check("busy_at_done", busy, 0);
        check("ab_final", {30'd0, a, b}, (sel > 3'd5) ? 0 : 3);
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            x = sb.pop_front();
            check("pass", pass, x.p);
            check("err_count", err_count, x.e);
            check("fail_vec", fail_vec, x.f);
        end
        tick;
        check("done_pulse", done, 0);
        check("hold_err", err_count, (sel > 3'd5) ? 4 : err_count);
    endtask

    task automatic run(input logic [2:0] sel, input int m);
        model    = m;
        gate_sel = sel;
        start    = 1'b1;
        push_exp(sel, m);
        tick;
        start = 1'b0;
        wait_done(sel, 1'b0);
    endtask

    initial begin
        int n;
        tick;
        tick;
        check("reset_outs", {a, b, busy, done, pass, err_count, fail_vec}, 0);
        rst_n = 1'b1;
        tick;

        run(3'd2, 0);   // NAND vs NAND
        run(3'd2, 1);   // NAND vs AND
        run(3'd2, 2);   // NAND vs stuck-at-0
        run(3'd6, 0);   // reserved
        run(3'd7, 1);   // reserved
        run(3'd0, 1);   // AND vs AND
        run(3'd4, 0);   // XOR vs NAND

        // Reset mid-run while {a,b}=10.
        model    = 0;
        gate_sel = 3'd2;
        start    = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while ({a, b} != 2'b10 && n < 50) begin
            tick;
            n++;
        end
        check("reach_ab10", {30'd0, a, b}, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {a, b, busy, done, pass, err_count, fail_vec}, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("no_done_in_reset", done, 0);
        end
        rst_n = 1'b1;
        tick;
        check("no_done_after_reset", {done, busy}, 0);
        run(3'd2, 0);

        // start held high with gate_sel toggling: one run, then a fresh run from IDLE.
        model    = 0;
        gate_sel = 3'd2;
        start    = 1'b1;
        push_exp(3'd2, 0);
        tick;
        wait_done(3'd2, 1'b1);
        check("idle_gap_busy", busy, 0);
        gate_sel = 3'd2;
        push_exp(3'd2, 0);
        tick;
        start = 1'b0;
        wait_done(3'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gate_truth_checker.md
GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, giving the number of cycles to wait after driving each vector; legal range 1..15.
REQ-002 SHALL have clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have start, input, 1, a run request, sampled only in IDLE.
REQ-005 SHALL have gate_sel, input, 3, the gate under test, latched at start: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6-7 reserved.
REQ-006 SHALL have a, output, 1, the first operand driven to the external 2-input gate DUT.
REQ-007 SHALL have b, output, 1, the second operand driven to the DUT.
REQ-008 SHALL have y, input, 1, the DUT output.
REQ-009 SHALL have busy, output, 1, high while a run is in progress (SETTLE or CHECK).
REQ-010 SHALL have done, output, 1, a one-cycle pulse at the end of a run.
REQ-011 SHALL have pass, output, 1, which is 1 when all 4 vectors matched; valid from done until the next accepted start.
REQ-012 SHALL have err_count, output, 3, the number of mismatching vectors (0..4).
REQ-013 SHALL have fail_vec, output, 4, where bit i=1 means vector i mismatched; vector i = {a,b} = i.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, CHECK and DONE.
REQ-015 In IDLE with start=1 at edge E0, the block SHALL latch gate_sel, clear err_count/fail_vec/pass, load {a,b}=2'b00, load the settle counter with SETTLE_CYCLES, and go to SETTLE.
REQ-016 In SETTLE, the block SHALL decrement the counter each cycle and go to CHECK after SETTLE_CYCLES cycles.
REQ-017 In CHECK, the block SHALL sample y at the edge leaving CHECK and compare it to the expected truth-table value for the latched gate_sel and the current {a,b}.
REQ-018 On a mismatch, the block SHALL increment err_count and set fail_vec[{a,b}].
REQ-019 A y value of X or Z SHALL count as a mismatch.
REQ-020 On the edge leaving CHECK with {a,b}<3, the block SHALL increment {a,b}, reload the counter, and return to SETTLE.
REQ-021 On the edge leaving CHECK with {a,b}=3, the block SHALL go to DONE with pass=(no mismatches).
REQ-022 Vector i SHALL be sampled at edge E0+(i+1)*(SETTLE_CYCLES+1).
REQ-023 done SHALL be high for exactly one cycle, following edge E0+4*(SETTLE_CYCLES+1); DONE SHALL then return to IDLE.
REQ-024 With a reserved gate_sel at start, the block SHALL go directly to DONE: done high in the cycle after E0, pass=0, err_count=4, fail_vec=4'b1111, and a/b held at 0.
REQ-025 start SHALL be ignored in SETTLE, CHECK and DONE; it is accepted again from IDLE (earliest one cycle after done).
REQ-026 Changes to gate_sel after E0 SHALL have no effect on the current run.
REQ-027 a and b SHALL hold the last vector after a run until the next start.
REQ-028 pass, err_count and fail_vec SHALL hold their values until the next accepted start.
REQ-029 busy SHALL be 1 exactly when the state is SETTLE or CHECK.

Reset
REQ-030 rst_n=0 SHALL immediately force: state IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, counter=0.
REQ-031 A reset mid-run SHALL abort the run with no done pulse.
REQ-032 After rst_n deasserts, the first start SHALL begin a fresh run.

Verification
REQ-033 Correct NAND DUT model, gate_sel=2, SETTLE_CYCLES=2, start pulse -> {a,b} steps 00,01,10,11 at edges E0,E0+3,E0+6,E0+9; done high for one cycle after E0+12; pass=1, err_count=0, fail_vec=0000.
REQ-034 AND model connected, gate_sel=2 -> pass=0, err_count=4, fail_vec=1111.
REQ-035 y stuck at 0, gate_sel=2 -> err_count=3, fail_vec=0111, pass=0.
REQ-036 gate_sel=6 at start -> done one cycle after E0, pass=0, err_count=4, fail_vec=1111, busy never high.
REQ-037 rst_n pulsed low while {a,b}=10 -> all outputs 0 immediately and no done pulse; a new start with the NAND model then passes.
REQ-038 start held high for the whole run with gate_sel toggling -> one run only, using the gate_sel latched at E0; the next run begins from IDLE one cycle after done.
